fir_dac_bridge: RTL and testbench

- Sits between the FIR Avalon-ST source output and the AUDIO_DAC host write port.
- Converts each 27-bit signed filter result to a 24-bit signed DAC word by rounding and saturating.
- Buffers converted samples in a small FIFO.
- Writes every sample twice to the DAC FIFO, left then right, honouring the DAC's full flag.
- Counts dropped samples and flags saturation.

---
 rtl/fir_dac_bridge.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_fir_dac_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_dac_bridge.sv
// fir_dac_bridge
//   Bridges the FIR Avalon-ST source to the AUDIO_DAC host write port.
//   Each accepted 27-bit signed filter result is rounded, shifted right and
//   saturated to a 24-bit signed DAC word, buffered in a small FIFO, and then
//   written twice (left, then right) while honouring the DAC full flag.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_sink_data/valid/err  FIR ast_source data, valid, error
//   i_flush             synchronous flush: empties FIFO, drops stage 1, FSM to IDLE
//   o_dac_write         write strobe to AUDIO_DAC (combinational)
//   o_dac_write_data    write data to AUDIO_DAC (hold register)
//   i_dac_full          AUDIO_DAC full flag
//   o_dac_clear         one-cycle pulse the cycle after a flush
//   o_drop_cnt          saturating count of error drops and FIFO overflow drops
//   o_sat               sticky saturation flag, cleared only by reset
//   o_busy              FIFO non-empty or FSM not idle
//
// Build option:
//   FIR_DAC_DITHER_EN   when defined, a 16-bit LFSR supplies the rounding bits
//                       (rectangular dither) instead of the half-LSB constant.
module fir_dac_bridge #(
    parameter int pIN_DW      = 27,
    parameter int pDAC_DW     = 24,
    parameter int pSHIFT      = 3,
    parameter int pFIFO_DEPTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [pIN_DW-1:0]    i_sink_data,
    input  logic                 i_sink_valid,
    input  logic [1:0]           i_sink_err,
    input  logic                 i_flush,
    output logic                 o_dac_write,
    output logic [pDAC_DW-1:0]   o_dac_write_data,
    input  logic                 i_dac_full,
    output logic                 o_dac_clear,
    output logic [15:0]          o_drop_cnt,
    output logic                 o_sat,
    output logic                 o_busy
);

    localparam int AW = $clog2(pFIFO_DEPTH);

    // Clamp bounds expressed at the widened conversion width.
    localparam logic signed [pIN_DW:0] SAT_MAX =
        {{(pIN_DW-pDAC_DW+2){1'b0}}, {(pDAC_DW-1){1'b1}}};
    localparam logic signed [pIN_DW:0] SAT_MIN =
        {{(pIN_DW-pDAC_DW+2){1'b1}}, {(pDAC_DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        WR_L,
        WR_R
    } state_t;

    // ------------------------------------------------------------------
    // Input qualification (a flush cycle swallows any input silently)
    // ------------------------------------------------------------------
    logic accept;
    logic err_drop;

    assign accept   = i_sink_valid && (i_sink_err == 2'b00) && !i_flush;
    assign err_drop = i_sink_valid && (i_sink_err != 2'b00) && !i_flush;

    // ------------------------------------------------------------------
    // Rounding constant
    // ------------------------------------------------------------------
    logic signed [pIN_DW:0] rnd;

`ifdef FIR_DAC_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting towards bit 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_comb begin
        rnd = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < unsigned'(pSHIFT)) begin
                rnd[i] = lfsr[i];
            end
        end
    end
`else
    if (pSHIFT > 0) begin : g_round
        assign rnd = (pIN_DW+1)'(1) << (pSHIFT - 1);
    end else begin : g_no_round
        assign rnd = '0;
    end
`endif

    // ------------------------------------------------------------------
    // Conversion: sign-extend, round, arithmetic shift, saturate
    // ------------------------------------------------------------------
    logic signed [pIN_DW:0] ext;
    logic signed [pIN_DW:0] sum;
    logic signed [pIN_DW:0] shifted;
    logic [pDAC_DW-1:0]     conv;
    logic                   clamp;

    always_comb begin
        ext     = {i_sink_data[pIN_DW-1], i_sink_data};
        sum     = ext + rnd;
        shifted = sum >>> pSHIFT;
        clamp   = 1'b0;
        conv    = shifted[pDAC_DW-1:0];
        if (shifted > SAT_MAX) begin
            conv  = {1'b0, {(pDAC_DW-1){1'b1}}};
            clamp = 1'b1;
        end else if (shifted < SAT_MIN) begin
            conv  = {1'b1, {(pDAC_DW-1){1'b0}}};
            clamp = 1'b1;
        end
    end

    // Stage 1 register
    logic               s1_valid;
    logic [pDAC_DW-1:0] s1_data;
    logic               sat;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            sat      <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= conv;
            end
            if (accept && clamp) begin
                sat <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [pDAC_DW-1:0] mem [pFIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push_ok;
    logic               ovf_drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(pFIFO_DEPTH));

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = s1_valid && !i_flush && (!fifo_full || pop);
    assign ovf_drop = s1_valid && !i_flush && fifo_full && !pop;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    // ------------------------------------------------------------------
    // Drop counter (error drop and overflow drop may coincide)
    // ------------------------------------------------------------------
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;
    logic [15:0] drop_cnt;

    assign drop_inc = {1'b0, err_drop} + {1'b0, ovf_drop};
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drop_cnt <= '0;
        end else begin
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Output FSM
    // ------------------------------------------------------------------
    state_t             state;
    state_t             state_next;
    logic               dac_write;
    logic [pDAC_DW-1:0] hold;
    logic               clear;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                hold <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        state_next = state;
        dac_write  = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = WR_L;
                end
            end
            WR_L: begin
                dac_write = !i_dac_full;
                if (dac_write) begin
                    state_next = WR_R;
                end
            end
            WR_R: begin
                dac_write = !i_dac_full;
                if (dac_write) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = WR_L;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides everything decided above.
        if (i_flush) begin
            dac_write  = 1'b0;
            pop        = 1'b0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            clear <= 1'b0;
        end else begin
            clear <= i_flush;
        end
    end

    assign o_dac_write      = dac_write;
    assign o_dac_write_data = hold;
    assign o_dac_clear      = clear;
    assign o_drop_cnt       = drop_cnt;
    assign o_sat            = sat;
    assign o_busy           = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_fir_dac_bridge.sv
// Directed bench for fir_dac_bridge with a scoreboard of expected DAC words.
module tb_fir_dac_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:0] sink_data;
    logic        sink_valid;
    logic [1:0]  sink_err;
    logic        flush;
    logic        dac_write;
    logic [23:0] dac_write_data;
    logic        dac_full;
    logic        dac_clear;
    logic [15:0] drop_cnt;
    logic        sat;
    logic        busy;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];
    int          wcyc_q[$];
    logic [23:0] mon_exp;
    int          acc;
    int          lat_l;
    int          lat_r;

    fir_dac_bridge #(
        .pIN_DW     (27),
        .pDAC_DW    (24),
        .pSHIFT     (3),
        .pFIFO_DEPTH(8)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_sink_data     (sink_data),
        .i_sink_valid    (sink_valid),
        .i_sink_err      (sink_err),
        .i_flush         (flush),
        .o_dac_write     (dac_write),
        .o_dac_write_data(dac_write_data),
        .i_dac_full      (dac_full),
        .o_dac_clear     (dac_clear),
        .o_drop_cnt      (drop_cnt),
        .o_sat           (sat),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference conversion: round half up by 4, floor divide by 8, clamp.
    function automatic logic [23:0] model(input logic [26:0] d);
        longint v;
        v = longint'($signed(d));
        v = (v + 4) >>> 3;
        if (v > 64'sd8388607)  v = 64'sd8388607;
        if (v < -64'sd8388608) v = -64'sd8388608;
        return v[23:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample for the next clock edge; optionally expect L+R output.
    task automatic send(input logic [26:0] d, input logic [1:0] e, input bit expect_out);
        @(posedge clk); #1;
        sink_data  = d;
        sink_valid = 1'b1;
        sink_err   = e;
        if (expect_out) begin
            exp_q.push_back(model(d));
            exp_q.push_back(model(d));
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        sink_valid = 1'b0;
        sink_err   = 2'b00;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(k < 300), 32'd1);
    endtask

    // Scoreboard monitor: every DAC write must match the next expected word.
    always @(negedge clk) begin
        if (!rst && dac_write) begin
            wcyc_q.push_back(cyc);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%0h expected=none", dac_write_data);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert (dac_write_data === mon_exp) else begin
                    errors++;
                    $error("FAIL dac_data observed=%0h expected=%0h", dac_write_data, mon_exp);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        sink_data  = '0;
        sink_valid = 1'b0;
        sink_err   = 2'b00;
        flush      = 1'b0;
        dac_full   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_write", 32'(dac_write), 32'd0);
        chk("rst_data", 32'(dac_write_data), 32'd0);
        chk("rst_clear", 32'(dac_clear), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Rounding and latency: 1000 -> 125 at N+3 (L) and N+4 (R)
        wcyc_q.delete();
        send(27'sd1000, 2'b00, 1'b1);
        acc = cyc;
        idle();
        drain();
        lat_l = (wcyc_q.size() > 0) ? wcyc_q[0] : -1;
        lat_r = (wcyc_q.size() > 1) ? wcyc_q[1] : -1;
        chk("nwrites_1000", 32'(wcyc_q.size()), 32'd2);
        chk("latency_L", 32'(lat_l), 32'(acc + 3));
        chk("latency_R", 32'(lat_r), 32'(acc + 4));
        chk("sat_after_1000", 32'(sat), 32'd0);

        // Negative rounding, back to back
        send(-27'sd5, 2'b00, 1'b1);
        send(-27'sd4, 2'b00, 1'b1);
        idle();
        drain();
        chk("sat_after_neg", 32'(sat), 32'd0);

        // Saturation
        send(27'h3FFFFFF, 2'b00, 1'b1);
        idle();
        drain();
        chk("sat_pos", 32'(sat), 32'd1);
        send(27'h4000000, 2'b00, 1'b1);
        idle();
        drain();
        chk("sat_sticky", 32'(sat), 32'd1);

        // Backpressure / overflow: samples converting to 1..10, 10 is dropped
        @(posedge clk); #1;
        dac_full = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            send(27'(k * 8), 2'b00, k <= 9);
        end
        idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("ovf_busy", 32'(busy), 32'd1);
        chk("ovf_no_write", 32'(dac_write), 32'd0);
        wcyc_q.delete();
        @(posedge clk); #1;
        dac_full = 1'b0;
        drain();
        chk("ovf_nwrites", 32'(wcyc_q.size()), 32'd18);
        chk("ovf_busy_end", 32'(busy), 32'd0);

        // Error drop
        send(27'sd800, 2'b01, 1'b0);
        idle();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("err_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("err_busy", 32'(busy), 32'd0);

        // Flush with the FSM in WR_R and 4 samples queued
        @(posedge clk); #1;
        dac_full = 1'b1;
        exp_q.push_back(model(27'd88));   // only the L write of sample 1 happens
        for (int k = 11; k <= 15; k++) begin
            send(27'(k * 8), 2'b00, 1'b0);
        end
        idle();
        repeat (4) @(posedge clk);
        #1;
        dac_full = 1'b0;                  // one L write of sample 1
        @(posedge clk); #1;
        dac_full = 1'b1;                  // now parked in WR_R
        @(posedge clk); #1;
        flush    = 1'b1;
        dac_full = 1'b0;
        @(negedge clk);
        chk("flush_no_write", 32'(dac_write), 32'd0);
        chk("flush_clear_same", 32'(dac_clear), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_clear", 32'(dac_clear), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_drop", 32'(drop_cnt), 32'd2);
        @(negedge clk);
        chk("flush_clear_end", 32'(dac_clear), 32'd0);
        repeat (10) @(negedge clk);
        chk("flush_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("flush_sat_kept", 32'(sat), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
